// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranger: periodic trigger, echo timing, cm conversion.
// Holds last good reading; flags lost or stuck echoes.
module ultrasonic_ranger #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int TRIG_US     = 10,
  parameter int PERIOD_MS   = 60,
  parameter int TIMEOUT_US  = 25_000,
  parameter int US_PER_CM   = 58
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance,
  output logic        dist_valid,
  output logic        echo_timeout,
  output logic        busy
);

  localparam int CYC_US      = CLK_FREQ_HZ / 1_000_000;
  localparam int CYC_PER_CM  = CYC_US * US_PER_CM;
  localparam int TRIG_CYC    = CYC_US * TRIG_US;
  localparam int PERIOD_CYC  = CYC_US * PERIOD_MS * 1000;
  localparam int TIMEOUT_CYC = CYC_US * TIMEOUT_US;
  localparam int PH_MAX      = (TRIG_CYC > TIMEOUT_CYC) ? TRIG_CYC : TIMEOUT_CYC;

  localparam int PW = $clog2(PERIOD_CYC + 1);
  localparam int HW = $clog2(PH_MAX + 1);
  localparam int SW = $clog2(CYC_PER_CM + 1);

  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYC - 1);
  localparam logic [HW-1:0] TRIG_LAST = HW'(TRIG_CYC - 1);
  localparam logic [HW-1:0] TMO_LAST  = HW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] PRE_LAST  = SW'(CYC_PER_CM - 1);

  if (TRIG_CYC + 2 * TIMEOUT_CYC + 4 >= PERIOD_CYC) begin : g_cfg_err
    $error("ultrasonic_ranger: PERIOD too short for trigger plus two timeouts");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_R, S_MEAS, S_DONE, S_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [HW-1:0] ph_q, ph_d;
  logic [SW-1:0] pre_q, pre_d;
  logic [15:0]   cm_q, cm_d;
  logic [15:0]   dist_q, dist_d;
  logic          tmo_q, tmo_d;
  logic [1:0]    sync_q, sync_d;
  logic          echo_d_q, echo_d_d;

  logic        echo_s, rise, fall, start;
  logic        pre_wrap;
  logic [15:0] cm_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      per_q    <= '0;
      ph_q     <= '0;
      pre_q    <= '0;
      cm_q     <= '0;
      dist_q   <= '0;
      tmo_q    <= 1'b0;
      sync_q   <= '0;
      echo_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      ph_q     <= ph_d;
      pre_q    <= pre_d;
      cm_q     <= cm_d;
      dist_q   <= dist_d;
      tmo_q    <= tmo_d;
      sync_q   <= sync_d;
      echo_d_q <= echo_d_d;
    end
  end

  always_comb begin
    sync_d   = {sync_q[0], echo};
    echo_s   = sync_q[1];
    echo_d_d = echo_s;
    rise     = echo_s & ~echo_d_q;
    fall     = ~echo_s & echo_d_q;
    start    = (per_q == '0) & en;
    per_d    = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
    pre_wrap = (pre_q == PRE_LAST);
    // cm count including the current cycle, so capture is floor(cycles/CYC_PER_CM)
    cm_nxt   = (pre_wrap && cm_q != 16'hFFFF) ? cm_q + 16'd1 : cm_q;
  end

  always_comb begin
    state_d = state_q;
    ph_d    = '0;
    pre_d   = pre_q;
    cm_d    = cm_q;
    dist_d  = dist_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (ph_q == TRIG_LAST) state_d = S_WAIT_R;
        else ph_d = ph_q + 1'b1;
      end
      S_WAIT_R: begin
        if (rise) begin
          state_d = S_MEAS;
          pre_d   = '0;
          cm_d    = '0;
        end else if (ph_q == TMO_LAST) begin
          state_d = S_FAIL;
          tmo_d   = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_MEAS: begin
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        cm_d  = cm_nxt;
        if (fall) begin
          state_d = S_DONE;
          dist_d  = cm_nxt;
          tmo_d   = 1'b0;
        end else if (ph_q == TMO_LAST) begin
          state_d = S_FAIL;
          tmo_d   = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    trig         = (state_q == S_TRIG);
    busy         = (state_q == S_TRIG) || (state_q == S_WAIT_R) ||
                   (state_q == S_MEAS);
    dist_valid   = (state_q == S_DONE);
    distance     = dist_q;
    echo_timeout = tmo_q;
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Randomized self-checking bench for ultrasonic_ranger.
// Reference: distance = floor(echo_width / 58), 800-cycle timeouts, 2000-cycle period.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

  localparam int CPC    = 58;
  localparam int PERIOD = 2000;
  localparam int TRIGW  = 10;
  localparam int TMO    = 800;

  logic        clk = 1'b0;
  logic        rst, en, echo;
  logic        trig, dist_valid, echo_timeout, busy;
  logic [15:0] distance;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_trig = -1;
  int exp_dist = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ultrasonic_ranger #(
    .CLK_FREQ_HZ(1_000_000),
    .TRIG_US(10),
    .PERIOD_MS(2),
    .TIMEOUT_US(800),
    .US_PER_CM(58)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .echo(echo),
    .trig(trig),
    .distance(distance),
    .dist_valid(dist_valid),
    .echo_timeout(echo_timeout),
    .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the first negedge where trig has dropped again.
  task automatic wait_trig(output int polls);
    int hi;
    polls = 0;
    while (trig !== 1'b1 && polls < PERIOD + 100) begin
      @(negedge clk);
      polls++;
    end
    if (trig !== 1'b1) begin
      check_eq("trig_seen", {31'd0, trig}, 1);
      return;
    end
    if (last_trig >= 0) check_eq("trig_period", cyc - last_trig, PERIOD);
    last_trig = cyc;
    check_eq("busy_trig", {31'd0, busy}, 1);
    hi = 0;
    while (trig === 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    check_eq("trig_width", hi, TRIGW);
  endtask

  // w == 0 means no echo at all (or an echo already stuck high).
  task automatic meas(input int d, input int w);
    int k, dv, lat;
    if (w == 0) begin
      k = 0;
      dv = 0;
      while (busy === 1'b1 && k < 2 * PERIOD) begin
        @(negedge clk);
        k++;
        if (dist_valid === 1'b1) dv++;
      end
      check_eq("tmo_lat", k, TMO);
      check_eq("tmo_flag", {31'd0, echo_timeout}, 1);
      check_eq("tmo_no_dv", dv, 0);
      check_eq("tmo_hold", {16'd0, distance}, exp_dist);
    end else begin
      repeat (d) @(negedge clk);
      echo = 1'b1;
      repeat (w) @(negedge clk);
      echo = 1'b0;
      exp_dist = w / CPC;
      dv = 0;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (dist_valid === 1'b1) begin
          dv++;
          if (lat == 0) begin
            lat = i;
            check_eq("dist", {16'd0, distance}, exp_dist);
            check_eq("tmo_clr", {31'd0, echo_timeout}, 0);
          end
        end
      end
      check_eq("dv_count", dv, 1);
      check_eq("dv_lat", lat, 3);
    end
  endtask

  initial begin
    int p, hi_cnt;
    int widths[4] = '{637, 638, 57, 637};
    rst = 1'b1;
    en = 1'b1;
    echo = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_trig", {31'd0, trig}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_dist", {16'd0, distance}, 0);
    check_eq("rst_dv", {31'd0, dist_valid}, 0);
    check_eq("rst_tmo", {31'd0, echo_timeout}, 0);
    rst = 1'b0;

    wait_trig(p);
    check_eq("first_trig", p, 1);
    meas(100, 580);

    foreach (widths[i]) begin
      wait_trig(p);
      meas(100, widths[i]);
    end

    wait_trig(p);
    meas(0, 0);
    wait_trig(p);
    meas(100, 290);

    for (int i = 0; i < 12; i++) begin
      wait_trig(p);
      if ($urandom_range(0, 4) == 0) meas(0, 0);
      else meas($urandom_range(0, 700), $urandom_range(1, 780));
    end

    wait_trig(p);
    meas(100, 580);
    echo = 1'b1;
    wait_trig(p);
    meas(0, 0);
    wait_trig(p);
    meas(0, 0);
    echo = 1'b0;

    wait_trig(p);
    en = 1'b0;
    meas(100, 580);
    hi_cnt = 0;
    for (int i = 0; i < 2 * PERIOD + 200; i++) begin
      @(negedge clk);
      if (trig !== 1'b0 || busy !== 1'b0) hi_cnt++;
    end
    check_eq("en_off_quiet", hi_cnt, 0);
    en = 1'b1;
    last_trig = -1;

    wait_trig(p);
    repeat (50) @(negedge clk);
    echo = 1'b1;
    repeat (302) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_trig", {31'd0, trig}, 0);
    check_eq("mid_rst_busy", {31'd0, busy}, 0);
    check_eq("mid_rst_dist", {16'd0, distance}, 0);
    check_eq("mid_rst_dv", {31'd0, dist_valid}, 0);
    check_eq("mid_rst_tmo", {31'd0, echo_timeout}, 0);
    exp_dist = 0;
    echo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_trig = -1;
    wait_trig(p);
    check_eq("rst_first_trig", p, 1);
    meas(100, 580);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got cycle %0d expected end of test", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
